overlap_slice_merger: RTL and testbench
=======================================

// Module: overlap_slice_merger
// PURPOSE
//  Reassembles a W-bit bus word from two overlapping slice streams: low slice
//  (bits [LO_W-1:0]) and high slice (bits [W-1:W-HI_W]). Inverse of the
//  overlapping-alias bus split; sits where the two slice producers rejoin the
//  full-width datapath. Buffers one slice per side, emits one merged word with
//  valid/ready, optionally checks that the overlapping bits agree.
// PARAMETERS
//  W     16  full bus width
//  LO_W  12  low slice width, maps to out bits [LO_W-1:0]
//  HI_W  12  high slice width, maps to out bits [W-1:W-HI_W]; LO_W+HI_W >= W required
//            (overlap OV = LO_W+HI_W-W; OV=0 is legal, no check possible)
// PORTS
//  clk       in   1     clock, all logic rising-edge
//  rst       in   1     reset, synchronous, active-high
//  lo_valid  in   1     low slice valid
//  lo_ready  out  1     low slice accepted when lo_valid&lo_ready
//  lo_data   in   LO_W  low slice data
//  hi_valid  in   1     high slice valid
//  hi_ready  out  1     high slice accepted when hi_valid&hi_ready
//  hi_data   in   HI_W  high slice data
//  out_valid out  1     merged word valid
//  out_ready in   1     downstream accept
//  out_data  out  W     merged word
//  out_err   out  1     overlap mismatch for current out_data (qualified by out_valid)
//  err_cnt   out  8     saturating mismatch count
// BEHAVIOUR
//  - Reset: state=IDLE, held slices cleared, out_valid=0, out_data=0, out_err=0,
//    err_cnt=0, lo_ready=1, hi_ready=1 from first cycle after reset.
//  - States: IDLE, HAVE_LO, HAVE_HI, OUT.
//    IDLE:    lo only -> HAVE_LO; hi only -> HAVE_HI; both same cycle -> OUT.
//    HAVE_LO: lo_ready=0, hi_ready=1; hi accept -> OUT.
//    HAVE_HI: hi_ready=0, lo_ready=1; lo accept -> OUT.
//    OUT:     lo_ready=hi_ready=0, out_valid=1; out_valid&out_ready -> IDLE.
//  - Latency: out_valid rises the cycle after the second slice is accepted.
//    Throughput: max one word per 2 cycles (no accept during OUT).
//  - Merge: out_data[LO_W-1:0]=lo; out_data[W-1:LO_W]=hi[HI_W-1:HI_W-(W-LO_W)];
//    overlap bits [LO_W-1:W-HI_W] taken from hi (high slice wins).
//  - out_data/out_err registered on entry to OUT; held stable while
//    out_valid&!out_ready. out_valid never drops without handshake.
//  - Slice never accepted twice: a second lo while HAVE_LO stalls (lo_ready=0).
//  - rst mid-operation: held slices and pending output discarded, same-cycle
//    handshakes ignored; err_cnt cleared.
// CONFIGURATION
//  OVERLAP_CHECK_EN defined: lo overlap bits compared to hi overlap bits at
//    merge; out_err=1 on mismatch; err_cnt += 1 on each OUT entry with mismatch,
//    saturates at 255. OV=0 -> never mismatches.
//  OVERLAP_CHECK_EN undefined: no compare logic; out_err and err_cnt tied 0;
//    merge data unchanged (hi wins).
// TESTING
//  1 lo=0xABC, hi=0x5AB same cycle -> next cycle out_valid=1, out_data=0x5ABC, out_err=0.
//  2 lo=0x123, hi=0xFFF -> out_data=0xFFF3; with EN out_err=1, err_cnt=1; without EN out_err=0, err_cnt=0.
//  3 hi=0x5AB accepted, lo=0xABC 3 cycles later -> hi_ready=0 meanwhile, out_valid
//    one cycle after lo accept, out_data=0x5ABC.
//  4 out_ready=0 for 5 cycles with out_valid=1 -> out_data stable, lo_ready=hi_ready=0;
//    out_ready=1 -> IDLE next cycle, readies return to 1.
//  5 lo=0xABC accepted, rst pulsed 1 cycle, then hi=0x5AB alone -> no out_valid (state HAVE_HI).
//  6 (EN) 300 consecutive mismatching pairs -> err_cnt=255, no wrap.

Source files
------------

// File: rtl/overlap_slice_merger_if.sv
// Handshake bundle for overlap_slice_merger: low/high slice inputs, merged word output.
// master = producers/consumer side, slave = the merger.
interface overlap_slice_merger_if #(
  parameter int W    = 16,
  parameter int LO_W = 12,
  parameter int HI_W = 12
);
  logic            lo_valid;
  logic            lo_ready;
  logic [LO_W-1:0] lo_data;
  logic            hi_valid;
  logic            hi_ready;
  logic [HI_W-1:0] hi_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_err;
  logic [7:0]      err_cnt;

  modport master (
    output lo_valid, lo_data, hi_valid, hi_data, out_ready,
    input  lo_ready, hi_ready, out_valid, out_data, out_err, err_cnt
  );

  modport slave (
    input  lo_valid, lo_data, hi_valid, hi_data, out_ready,
    output lo_ready, hi_ready, out_valid, out_data, out_err, err_cnt
  );
endinterface

// File: rtl/overlap_slice_merger.sv
// Rejoins overlapping low/high slices into one W-bit word; the high slice owns the overlap.
// Optional overlap compare and saturating mismatch counter enabled by OVERLAP_CHECK_EN.
//
// state   | meaning
// IDLE    | no slice held, both slice inputs ready
// HAVE_LO | low slice held, waiting for high slice
// HAVE_HI | high slice held, waiting for low slice
// OUT     | merged word presented, waiting for downstream accept
module overlap_slice_merger #(
  parameter int W    = 16,
  parameter int LO_W = 12,
  parameter int HI_W = 12
) (
  input logic                  clk,
  input logic                  rst,
  overlap_slice_merger_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HAVE_LO = 2'd1;
  localparam logic [1:0] HAVE_HI = 2'd2;
  localparam logic [1:0] OUT     = 2'd3;

  localparam int         HI_LSB  = W - HI_W;
  localparam logic [W-1:0] ONES    = '1;
  localparam logic [W-1:0] LO_KEEP = ~(ONES << HI_LSB);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [LO_W-1:0] lo_q;
  logic [HI_W-1:0] hi_q;
  logic [W-1:0]    out_data_q;
  logic            lo_rdy;
  logic            hi_rdy;
  logic            lo_acc;
  logic            hi_acc;
  logic            enter_out;
  logic [LO_W-1:0] lo_src;
  logic [HI_W-1:0] hi_src;
  logic [W-1:0]    lo_ext;
  logic [W-1:0]    hi_ext;
  logic [W-1:0]    merged;

  always_comb begin
    lo_rdy = (state == IDLE) || (state == HAVE_HI);
    hi_rdy = (state == IDLE) || (state == HAVE_LO);
    lo_acc = bus.lo_valid && lo_rdy;
    hi_acc = bus.hi_valid && hi_rdy;

    state_nxt = state;
    case (state)
      IDLE: begin
        if (lo_acc && hi_acc) state_nxt = OUT;
        else if (lo_acc)      state_nxt = HAVE_LO;
        else if (hi_acc)      state_nxt = HAVE_HI;
      end
      HAVE_LO: if (hi_acc)        state_nxt = OUT;
      HAVE_HI: if (lo_acc)        state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    enter_out = (state != OUT) && (state_nxt == OUT);

    // The slice arriving this cycle bypasses its holding register.
    lo_src = lo_acc ? bus.lo_data : lo_q;
    hi_src = hi_acc ? bus.hi_data : hi_q;
    lo_ext = W'(lo_src);
    hi_ext = W'(hi_src) << HI_LSB;
    merged = (lo_ext & LO_KEEP) | hi_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      out_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (lo_acc)    lo_q       <= bus.lo_data;
      if (hi_acc)    hi_q       <= bus.hi_data;
      if (enter_out) out_data_q <= merged;
    end
  end

  assign bus.lo_ready  = lo_rdy;
  assign bus.hi_ready  = hi_rdy;
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = out_data_q;

`ifdef OVERLAP_CHECK_EN
  // Overlap window is bits [LO_W-1:HI_LSB]; empty (never mismatches) when LO_W+HI_W == W.
  localparam logic [W-1:0] OV_MASK = (ONES >> (W - LO_W)) & (ONES << HI_LSB);

  logic       mism;
  logic       out_err_q;
  logic [7:0] err_cnt_q;

  assign mism = |((lo_ext ^ hi_ext) & OV_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_err_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else if (enter_out) begin
      out_err_q <= mism;
      if (mism && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.out_err = out_err_q;
  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.out_err = 1'b0;
  assign bus.err_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_overlap_slice_merger.sv
// Directed plus randomized bench for overlap_slice_merger against an arithmetic merge model.
// Honours OVERLAP_CHECK_EN so the same bench serves both builds.
module tb_overlap_slice_merger;
  localparam int W    = 16;
  localparam int LO_W = 12;
  localparam int HI_W = 12;
  localparam int OV   = LO_W + HI_W - W;
`ifdef OVERLAP_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  overlap_slice_merger_if #(.W(W), .LO_W(LO_W), .HI_W(HI_W)) bus ();

  overlap_slice_merger #(.W(W), .LO_W(LO_W), .HI_W(HI_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int merge_model(input int lo, input int hi);
    return (hi * (1 << (W - HI_W))) + (lo % (1 << (W - HI_W)));
  endfunction

  function automatic int err_model(input int lo, input int hi);
    if (!EN || OV == 0) return 0;
    return ((lo / (1 << (W - HI_W))) != (hi % (1 << OV))) ? 1 : 0;
  endfunction

  function automatic int sat_inc(input int cnt, input int mism);
    if (mism != 0 && cnt < 255) return cnt + 1;
    return cnt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LO_W-1:0] lo_v;
    logic [HI_W-1:0] hi_v;
    logic            lo_pend, hi_pend, lo_acc, hi_acc;
    int              lo_dly, hi_dly, cyc, stall, e, exp_word;

    bus.lo_valid = 1'b0; bus.lo_data = '0;
    bus.hi_valid = 1'b0; bus.hi_data = '0;
    bus.out_ready = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    rst = 1'b0;
    chk("rst_lo_ready", bus.lo_ready, 1);
    chk("rst_hi_ready", bus.hi_ready, 1);

    // both slices in the same cycle, matching overlap
    bus.lo_data = 12'hABC; bus.hi_data = 12'h5AB;
    bus.lo_valid = 1'b1; bus.hi_valid = 1'b1;
    tick();
    bus.lo_valid = 1'b0; bus.hi_valid = 1'b0;
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_out_data", bus.out_data, 32'h5ABC);
    chk("t1_out_err", bus.out_err, 0);
    chk("t1_lo_ready", bus.lo_ready, 0);
    drain();
    chk("t1_idle_valid", bus.out_valid, 0);

    // mismatching overlap, then held under backpressure
    bus.lo_data = 12'h123; bus.hi_data = 12'hFFF;
    bus.lo_valid = 1'b1; bus.hi_valid = 1'b1;
    tick();
    bus.lo_valid = 1'b0; bus.hi_valid = 1'b0;
    exp_cnt = sat_inc(exp_cnt, err_model(12'h123, 12'hFFF));
    chk("t2_out_data", bus.out_data, 32'hFFF3);
    chk("t2_out_err", bus.out_err, EN ? 1 : 0);
    chk("t2_err_cnt", bus.err_cnt, EN ? 1 : 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", bus.out_valid, 1);
      chk("t4_hold_data", bus.out_data, 32'hFFF3);
      chk("t4_hold_readies", {bus.lo_ready, bus.hi_ready}, 0);
    end
    drain();
    chk("t4_release_valid", bus.out_valid, 0);
    chk("t4_release_readies", {bus.lo_ready, bus.hi_ready}, 2'b11);

    // high first, low three cycles later; a second high must stall
    bus.hi_data = 12'h5AB; bus.hi_valid = 1'b1;
    tick();
    bus.hi_data = 12'h123;
    for (int i = 0; i < 2; i++) begin
      chk("t3_hi_ready", bus.hi_ready, 0);
      chk("t3_lo_ready", bus.lo_ready, 1);
      chk("t3_no_valid", bus.out_valid, 0);
      tick();
    end
    bus.lo_data = 12'hABC; bus.lo_valid = 1'b1;
    tick();
    bus.lo_valid = 1'b0; bus.hi_valid = 1'b0;
    chk("t3_out_valid", bus.out_valid, 1);
    chk("t3_out_data", bus.out_data, 32'h5ABC);
    drain();

    // reset while holding a low slice discards it
    bus.lo_data = 12'hABC; bus.lo_valid = 1'b1;
    tick();
    bus.lo_valid = 1'b0;
    rst = 1'b1;
    bus.hi_data = 12'h5AB; bus.hi_valid = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_err_cleared", bus.err_cnt, 0);
    exp_cnt = 0;
    tick();
    bus.hi_valid = 1'b0;
    chk("t5_no_valid", bus.out_valid, 0);
    chk("t5_hi_ready", bus.hi_ready, 0);
    chk("t5_lo_ready", bus.lo_ready, 1);
    bus.lo_data = 12'hAB0; bus.lo_valid = 1'b1;
    tick();
    bus.lo_valid = 1'b0;
    chk("t5_out_data", bus.out_data, 32'h5AB0);
    drain();

    // randomized arrival order, gaps and backpressure
    for (int t = 0; t < 150; t++) begin
      lo_v = 12'($urandom);
      hi_v = ($urandom_range(0, 1) == 1) ? {4'($urandom), lo_v[11:4]} : 12'($urandom);
      lo_dly = $urandom_range(0, 3);
      hi_dly = $urandom_range(0, 3);
      bus.lo_data = lo_v; bus.hi_data = hi_v;
      lo_pend = 1'b1; hi_pend = 1'b1; cyc = 0;
      while ((lo_pend || hi_pend) && cyc < 20) begin
        bus.lo_valid = lo_pend && (cyc >= lo_dly);
        bus.hi_valid = hi_pend && (cyc >= hi_dly);
        lo_acc = bus.lo_valid && bus.lo_ready;
        hi_acc = bus.hi_valid && bus.hi_ready;
        tick();
        if (lo_acc) lo_pend = 1'b0;
        if (hi_acc) hi_pend = 1'b0;
        cyc++;
        if (lo_pend || hi_pend) chk("rnd_early_valid", bus.out_valid, 0);
      end
      bus.lo_valid = 1'b0; bus.hi_valid = 1'b0;
      chk("rnd_accept_timeout", {lo_pend, hi_pend}, 0);
      exp_word = merge_model(int'(lo_v), int'(hi_v));
      e = err_model(int'(lo_v), int'(hi_v));
      exp_cnt = sat_inc(exp_cnt, e);
      chk("rnd_out_valid", bus.out_valid, 1);
      chk("rnd_out_data", bus.out_data, exp_word);
      chk("rnd_out_err", bus.out_err, e);
      chk("rnd_err_cnt", bus.err_cnt, exp_cnt);
      stall = $urandom_range(0, 3);
      repeat (stall) tick();
      chk("rnd_stall_data", bus.out_data, exp_word);
      drain();
      chk("rnd_done_valid", bus.out_valid, 0);
    end

    // 300 back-to-back mismatching words: counter saturates without wrapping
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk("t6_err_cleared", bus.err_cnt, 0);
    bus.lo_data = 12'h123; bus.hi_data = 12'hFFF;
    bus.lo_valid = 1'b1; bus.hi_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      tick();
      exp_cnt = sat_inc(exp_cnt, err_model(12'h123, 12'hFFF));
      if (i == 254 || i == 299) chk("t6_err_cnt", bus.err_cnt, exp_cnt);
    end
    bus.lo_valid = 1'b0; bus.hi_valid = 1'b0; bus.out_ready = 1'b0;
    chk("t6_final_cnt", bus.err_cnt, EN ? 255 : 0);
    chk("t6_idle", bus.out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
